// File: rtl/stage3_mem_access_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stage3_mem_access_unit_if : data-bus bundle between mem stage and dmem |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface stage3_mem_access_unit_if;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_en;
  logic        dmem_busy;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_ren, dmem_wen, dmem_addr, dmem_wdata, dmem_byte_en,
    input  dmem_busy, dmem_rdata
  );

  modport slave (
    input  dmem_ren, dmem_wen, dmem_addr, dmem_wdata, dmem_byte_en,
    output dmem_busy, dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/stage3_mem_access_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stage3_mem_access_unit : mem-stage load/store bus engine with stall    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module stage3_mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_CNT_W       = 16
) (
  input  wire logic                 CLK,
  input  wire logic                 nRST,
  input  wire logic                 valid_m,
  input  wire logic                 dren_m,
  input  wire logic                 dwen_m,
  input  wire logic [2:0]           load_type_m,
  input  wire logic [31:0]          addr_m,
  input  wire logic [31:0]          store_data_m,
  input  wire logic                 hold,
  stage3_mem_access_unit_if.master  dmem,
  output logic [31:0]               load_data,
  output logic                      mem_stall,
  output logic                      mal_load,
  output logic                      mal_store,
  output logic                      fault_load,
  output logic                      fault_store
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              r_state;
  logic [31:0]         r_addr;
  logic [2:0]          r_type;
  logic [31:0]         r_wdata;
  logic [3:0]          r_byte_en;
  logic                r_is_load;
  logic                r_ren;
  logic                r_wen;
  logic [31:0]         r_load_data;
  logic [TO_CNT_W-1:0] r_cnt;

  logic        w_half;
  logic        w_byte;
  logic        w_word;
  logic        w_mis;
  logic        w_accept;
  logic        w_done;
  logic        w_timeout;
  logic [3:0]  w_byte_en;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_fmt;

  assign w_half = (load_type_m == 3'b001) || (load_type_m == 3'b101);
  assign w_byte = (load_type_m == 3'b000) || (load_type_m == 3'b100);
  assign w_word = !w_half && !w_byte;
  assign w_mis  = (w_half && addr_m[0]) || (w_word && (addr_m[1:0] != 2'b00));

  assign w_accept = (r_state == IDLE) && valid_m && (dren_m || dwen_m) && !w_mis;
  assign w_done   = (r_state == ACCESS) && !dmem.dmem_busy;

  always_comb begin
    w_byte_en = 4'b1111;
    w_wdata   = store_data_m;
    if (w_byte) begin
      w_byte_en = 4'b0001 << addr_m[1:0];
      w_wdata   = {4{store_data_m[7:0]}};
    end else if (w_half) begin
      w_byte_en = 4'b0011 << {addr_m[1], 1'b0};
      w_wdata   = {2{store_data_m[15:0]}};
    end
  end

  // Load lane extraction uses the latched address/type, not the live ex/mem fields.
  assign w_shift = dmem.dmem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_fmt = w_shift;
    case (r_type)
      3'b000:  w_fmt = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_fmt = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_fmt = {24'd0, w_shift[7:0]};
      3'b101:  w_fmt = {16'd0, w_shift[15:0]};
      default: w_fmt = w_shift;
    endcase
  end

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
      localparam logic [TO_CNT_W-1:0] c_to_last = TO_CNT_W'(TIMEOUT_CYCLES - 1);
      assign w_timeout = (r_state == ACCESS) && dmem.dmem_busy && (r_cnt == c_to_last);
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  assign mem_stall   = w_accept || ((r_state == ACCESS) && dmem.dmem_busy && !w_timeout);
  assign mal_load    = (r_state == IDLE) && valid_m && dren_m && w_mis;
  assign mal_store   = (r_state == IDLE) && valid_m && dwen_m && !dren_m && w_mis;
  assign fault_load  = w_timeout && r_is_load;
  assign fault_store = w_timeout && !r_is_load;

  always_comb begin
    load_data = 32'd0;
    if (w_done && r_is_load) begin
      load_data = w_fmt;
    end else if (r_state == DONE) begin
      load_data = r_load_data;
    end
  end

  assign dmem.dmem_ren     = r_ren;
  assign dmem.dmem_wen     = r_wen;
  assign dmem.dmem_addr    = {r_addr[31:2], 2'b00};
  assign dmem.dmem_wdata   = r_wdata;
  assign dmem.dmem_byte_en = r_byte_en;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_addr      <= 32'd0;
      r_type      <= 3'd0;
      r_wdata     <= 32'd0;
      r_byte_en   <= 4'd0;
      r_is_load   <= 1'b0;
      r_ren       <= 1'b0;
      r_wen       <= 1'b0;
      r_load_data <= 32'd0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr    <= addr_m;
            r_type    <= load_type_m;
            r_wdata   <= w_wdata;
            r_byte_en <= w_byte_en;
            r_is_load <= dren_m;
            r_ren     <= dren_m;
            r_wen     <= !dren_m;
            r_cnt     <= '0;
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_timeout) begin
            r_ren       <= 1'b0;
            r_wen       <= 1'b0;
            r_load_data <= 32'd0;
            r_state     <= hold ? DONE : IDLE;
          end else if (!dmem.dmem_busy) begin
            r_ren       <= 1'b0;
            r_wen       <= 1'b0;
            r_load_data <= r_is_load ? w_fmt : 32'd0;
            r_state     <= hold ? DONE : IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          // Holds off re-issue while the stage is stalled by someone else.
          if (!hold) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage3_mem_access_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_stage3_mem_access_unit : directed bench for the mem access unit     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_stage3_mem_access_unit;
  logic        CLK;
  logic        nRST;
  logic        valid_m;
  logic        dren_m;
  logic        dwen_m;
  logic [2:0]  load_type_m;
  logic [31:0] addr_m;
  logic [31:0] store_data_m;
  logic        hold;
  logic [31:0] load_data,  load_data2;
  logic        mem_stall,  mem_stall2;
  logic        mal_load,   mal_load2;
  logic        mal_store,  mal_store2;
  logic        fault_load, fault_load2;
  logic        fault_store, fault_store2;

  int n_cmp = 0;
  int n_err = 0;

  stage3_mem_access_unit_if d1();
  stage3_mem_access_unit_if d2();

  stage3_mem_access_unit #(.TIMEOUT_CYCLES(4), .TO_CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .valid_m(valid_m), .dren_m(dren_m), .dwen_m(dwen_m),
    .load_type_m(load_type_m), .addr_m(addr_m), .store_data_m(store_data_m),
    .hold(hold), .dmem(d1), .load_data(load_data), .mem_stall(mem_stall),
    .mal_load(mal_load), .mal_store(mal_store), .fault_load(fault_load),
    .fault_store(fault_store)
  );

  // Second instance with the timeout disabled; its bus never answers.
  stage3_mem_access_unit #(.TIMEOUT_CYCLES(0), .TO_CNT_W(16)) dut_nto (
    .CLK(CLK), .nRST(nRST), .valid_m(valid_m), .dren_m(dren_m), .dwen_m(dwen_m),
    .load_type_m(load_type_m), .addr_m(addr_m), .store_data_m(store_data_m),
    .hold(hold), .dmem(d2), .load_data(load_data2), .mem_stall(mem_stall2),
    .mal_load(mal_load2), .mal_store(mal_store2), .fault_load(fault_load2),
    .fault_store(fault_store2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; valid_m = 1'b0; dren_m = 1'b0; dwen_m = 1'b0; load_type_m = 3'd0;
    addr_m = 32'd0; store_data_m = 32'd0; hold = 1'b0;
    d1.dmem_busy = 1'b0; d1.dmem_rdata = 32'd0;
    d2.dmem_busy = 1'b1; d2.dmem_rdata = 32'd0;
    step(); step(); #1;
    chk("rst_ren", {31'd0, d1.dmem_ren}, 32'd0);
    chk("rst_wen", {31'd0, d1.dmem_wen}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_byte_en", {28'd0, d1.dmem_byte_en}, 32'd0);
    chk("rst_addr", d1.dmem_addr, 32'd0);
    chk("rst_fault", {30'd0, fault_load, fault_store}, 32'd0);
    nRST = 1'b1;

    // LB 0x1003, zero-wait
    step(); valid_m = 1; dren_m = 1; load_type_m = 3'b000; addr_m = 32'h1003;
    d1.dmem_rdata = 32'h80FF0000; #1;
    chk("lb_accept_stall", {31'd0, mem_stall}, 32'd1);
    chk("lb_accept_ren", {31'd0, d1.dmem_ren}, 32'd0);
    step(); #1;
    chk("lb_ren", {31'd0, d1.dmem_ren}, 32'd1);
    chk("lb_byte_en", {28'd0, d1.dmem_byte_en}, 32'h8);
    chk("lb_addr", d1.dmem_addr, 32'h1000);
    chk("lb_stall", {31'd0, mem_stall}, 32'd0);
    chk("lb_data", load_data, 32'hFFFFFF80);
    valid_m = 0;
    step(); #1;
    chk("lb_idle_ren", {31'd0, d1.dmem_ren}, 32'd0);

    // LBU 0x1003
    step(); valid_m = 1; dren_m = 1; load_type_m = 3'b100; addr_m = 32'h1003; #1;
    chk("lbu_accept_stall", {31'd0, mem_stall}, 32'd1);
    step(); #1;
    chk("lbu_data", load_data, 32'h00000080);
    valid_m = 0;

    // SH 0x2002 with three busy cycles
    step(); valid_m = 1; dren_m = 0; dwen_m = 1; load_type_m = 3'b001; addr_m = 32'h2002;
    store_data_m = 32'h1234ABCD; d1.dmem_busy = 1; #1;
    chk("sh_accept_stall", {31'd0, mem_stall}, 32'd1);
    chk("sh_accept_wen", {31'd0, d1.dmem_wen}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(); d1.dmem_busy = (i < 3); #1;
      chk($sformatf("sh_wen_%0d", i), {31'd0, d1.dmem_wen}, 32'd1);
      chk($sformatf("sh_wdata_%0d", i), d1.dmem_wdata, 32'hABCDABCD);
      chk($sformatf("sh_be_%0d", i), {28'd0, d1.dmem_byte_en}, 32'hC);
      chk($sformatf("sh_addr_%0d", i), d1.dmem_addr, 32'h2000);
      chk($sformatf("sh_stall_%0d", i), {31'd0, mem_stall}, (i < 3) ? 32'd1 : 32'd0);
    end
    valid_m = 0; dwen_m = 0;
    step(); #1;
    chk("sh_idle_wen", {31'd0, d1.dmem_wen}, 32'd0);

    // Misaligned LW / SW
    step(); valid_m = 1; dren_m = 1; load_type_m = 3'b010; addr_m = 32'h3001; #1;
    chk("mal_lw_flag", {31'd0, mal_load}, 32'd1);
    chk("mal_lw_stall", {31'd0, mem_stall}, 32'd0);
    step(); #1;
    chk("mal_lw_ren", {31'd0, d1.dmem_ren}, 32'd0);
    dren_m = 0; dwen_m = 1; addr_m = 32'h3002; #1;
    chk("mal_sw_flag", {31'd0, mal_store}, 32'd1);
    chk("mal_sw_stall", {31'd0, mem_stall}, 32'd0);
    step(); #1;
    chk("mal_sw_wen", {31'd0, d1.dmem_wen}, 32'd0);

    // Valid with no memory op
    dwen_m = 0; addr_m = 32'h3000; #1;
    chk("nop_stall", {31'd0, mem_stall}, 32'd0);
    chk("nop_load_data", load_data, 32'd0);
    step(); #1;
    chk("nop_ren", {31'd0, d1.dmem_ren}, 32'd0);

    // LW with bus stuck busy: fault on 4th ACCESS cycle
    dren_m = 1; addr_m = 32'h5000; d1.dmem_busy = 1; #1;
    chk("to_accept_stall", {31'd0, mem_stall}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step(); #1;
      chk($sformatf("to_fault_%0d", k), {31'd0, fault_load}, (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("to_stall_%0d", k), {31'd0, mem_stall}, (k == 4) ? 32'd0 : 32'd1);
    end
    valid_m = 0; dren_m = 0;
    step(); #1;
    chk("to_after_ren", {31'd0, d1.dmem_ren}, 32'd0);
    chk("to_after_stall", {31'd0, mem_stall}, 32'd0);
    chk("to_after_fault", {30'd0, fault_load, fault_store}, 32'd0);
    chk("nto_stall", {31'd0, mem_stall2}, 32'd1);
    chk("nto_ren", {31'd0, d2.dmem_ren}, 32'd1);
    chk("nto_fault", {30'd0, fault_load2, fault_store2}, 32'd0);

    // LHU 0x4002 completing under hold
    d1.dmem_busy = 0; d1.dmem_rdata = 32'hBEEF0000;
    valid_m = 1; dren_m = 1; load_type_m = 3'b101; addr_m = 32'h4002; #1;
    chk("lhu_accept_stall", {31'd0, mem_stall}, 32'd1);
    step(); hold = 1; #1;
    chk("lhu_ren", {31'd0, d1.dmem_ren}, 32'd1);
    chk("lhu_data", load_data, 32'h0000BEEF);
    for (int j = 0; j < 3; j++) begin
      step(); #1;
      chk($sformatf("lhu_done_ren_%0d", j), {31'd0, d1.dmem_ren}, 32'd0);
      chk($sformatf("lhu_done_stall_%0d", j), {31'd0, mem_stall}, 32'd0);
      chk($sformatf("lhu_done_data_%0d", j), load_data, 32'h0000BEEF);
    end
    hold = 0; valid_m = 0; dren_m = 0;
    step(); #1;
    chk("lhu_idle_data", load_data, 32'd0);
    chk("lhu_idle_ren", {31'd0, d1.dmem_ren}, 32'd0);

    // Reset while an access is busy
    valid_m = 1; dren_m = 1; load_type_m = 3'b010; addr_m = 32'h6000; d1.dmem_busy = 1; #1;
    step(); #1;
    chk("rstacc_ren", {31'd0, d1.dmem_ren}, 32'd1);
    nRST = 0; valid_m = 0; dren_m = 0;
    step(); #1;
    chk("rstacc_ren_after", {31'd0, d1.dmem_ren}, 32'd0);
    chk("rstacc_stall_after", {31'd0, mem_stall}, 32'd0);
    chk("rstacc_data_after", load_data, 32'd0);
    chk("rstacc_fault_after", {30'd0, fault_load, fault_store}, 32'd0);
    nRST = 1; d1.dmem_busy = 0;

    // Aligned LW and byte store after recovery
    step(); valid_m = 1; dren_m = 1; load_type_m = 3'b010; addr_m = 32'h7000;
    d1.dmem_rdata = 32'h11223344; #1;
    step(); #1;
    chk("lw_be", {28'd0, d1.dmem_byte_en}, 32'hF);
    chk("lw_data", load_data, 32'h11223344);
    dren_m = 0; dwen_m = 1; load_type_m = 3'b000; addr_m = 32'h7001; store_data_m = 32'h000000A5;
    step(); #1;
    chk("sb_accept_stall", {31'd0, mem_stall}, 32'd1);
    step(); #1;
    chk("sb_wen", {31'd0, d1.dmem_wen}, 32'd1);
    chk("sb_be", {28'd0, d1.dmem_byte_en}, 32'h2);
    chk("sb_wdata", d1.dmem_wdata, 32'hA5A5A5A5);
    chk("sb_load_data", load_data, 32'd0);
    valid_m = 0; dwen_m = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
